// File: rtl/fetch_sequencer.sv
// Fetch sequencer: Moore FSM that walks the PC register through four byte
// reads per instruction, hands the assembled word to the decoder, then
// applies the decoder's next-PC command (sequential, jump, branch, halt).
// A per-request timeout moves the machine to a sticky FAULT state.
module fetch_sequencer #(
  parameter int TIMEOUT   = 200,
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  output logic        pc_read,
  output logic        pc_readplusone,
  output logic        pc_inc,
  output logic        pc_write,
  output logic        pc_offset,
  output logic [15:0] pc_din,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_target,
  input  logic        resume,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [3:0] {
    S_RST, S_F0, S_F1, S_INC0, S_F2, S_F3, S_INC1,
    S_VALID, S_WAITCMD, S_BRANCH, S_HALT, S_FAULT
  } state_t;

  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT - 1);

  state_t               state_q;
  logic [TIMEOUT_W-1:0] tcnt_q;
  logic [31:0]          instr_q;
  logic [15:0]          pc_din_q;
  // Selects which PC load BRANCH performs: 1 = relative offset, 0 = absolute write.
  logic                 br_rel_q;

  logic in_fetch;
  assign in_fetch = (state_q == S_F0) || (state_q == S_F1) ||
                    (state_q == S_F2) || (state_q == S_F3);

  // State register, byte capture, timeout counter and command latching.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_RST;
      tcnt_q   <= '0;
      instr_q  <= '0;
      pc_din_q <= '0;
      br_rel_q <= 1'b0;
    end else begin
      // The counter only runs while a fetch is waiting; every other state
      // leaves it at zero so each Fn is entered with a fresh budget.
      tcnt_q <= '0;
      case (state_q)
        S_RST: state_q <= S_F0;
        S_F0, S_F1, S_F2, S_F3: begin
          if (mem_ack) begin
            case (state_q)
              S_F0:    begin instr_q[31:24] <= mem_rdata; state_q <= S_F1;   end
              S_F1:    begin instr_q[23:16] <= mem_rdata; state_q <= S_INC0; end
              S_F2:    begin instr_q[15:8]  <= mem_rdata; state_q <= S_F3;   end
              default: begin instr_q[7:0]   <= mem_rdata; state_q <= S_INC1; end
            endcase
          end else if (tcnt_q == TO_LAST) begin
            state_q <= S_FAULT;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        S_INC0: state_q <= S_F2;
        S_INC1: state_q <= S_VALID;
        S_VALID: begin
          if (instr_ready) state_q <= S_WAITCMD;
        end
        S_WAITCMD: begin
          if (cmd_valid) begin
            pc_din_q <= cmd_target;
            case (cmd_op)
              2'b00:   state_q <= S_F0;
              2'b01:   begin br_rel_q <= 1'b0; state_q <= S_BRANCH; end
              2'b10:   begin br_rel_q <= 1'b1; state_q <= S_BRANCH; end
              default: state_q <= S_HALT;
            endcase
          end
        end
        S_BRANCH: state_q <= S_F0;
        S_HALT: begin
          if (resume) state_q <= S_F0;
        end
        S_FAULT: state_q <= S_FAULT;
        default: state_q <= S_RST;
      endcase
    end
  end

  assign mem_req        = in_fetch;
  assign pc_read        = (state_q == S_F0) || (state_q == S_F2);
  assign pc_readplusone = (state_q == S_F1) || (state_q == S_F3);
  assign pc_inc         = (state_q == S_INC0) || (state_q == S_INC1);
  assign pc_write       = (state_q == S_BRANCH) && !br_rel_q;
  assign pc_offset      = (state_q == S_BRANCH) && br_rel_q;
  assign pc_din         = pc_din_q;
  assign instr          = instr_q;
  assign instr_valid    = (state_q == S_VALID);
  assign halted         = (state_q == S_HALT);
  assign fault          = (state_q == S_FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural PC register and a
// byte memory whose contents are a fixed function of the address.
module tb_fetch_sequencer;

  localparam int TO = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_read, pc_readplusone, pc_inc, pc_write, pc_offset;
  logic [15:0] pc_din;
  logic        mem_req, mem_ack;
  logic [7:0]  mem_rdata;
  logic [31:0] instr;
  logic        instr_valid, instr_ready;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_target;
  logic        resume, halted, fault;

  logic        ack_en;
  logic        pc_rst;
  logic [15:0] pc_m;
  logic [15:0] addr_m;
  int          tests  = 0;
  int          failed = 0;
  int          inc_cnt = 0;
  int          overlap = 0;

  fetch_sequencer #(.TIMEOUT(TO), .TIMEOUT_W(8)) dut (
    .clk(clk), .reset(reset),
    .pc_read(pc_read), .pc_readplusone(pc_readplusone), .pc_inc(pc_inc),
    .pc_write(pc_write), .pc_offset(pc_offset), .pc_din(pc_din),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_target(cmd_target),
    .resume(resume), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    case (a)
      16'h0000: return 8'h12;
      16'h0001: return 8'h34;
      16'h0002: return 8'h56;
      16'h0003: return 8'h78;
      default:  return a[7:0] + 8'h40;
    endcase
  endfunction

  // PC register model driven by the DUT strobes.
  always @(posedge clk) begin
    if (pc_rst)         pc_m <= 16'h0000;
    else if (pc_inc)    pc_m <= pc_m + 16'd2;
    else if (pc_write)  pc_m <= pc_din;
    else if (pc_offset) pc_m <= pc_m + pc_din;
  end

  assign addr_m    = pc_read ? pc_m : pc_m + 16'd1;
  assign mem_rdata = mem_byte(addr_m);
  assign mem_ack   = ack_en & mem_req;

  // Strobe exclusivity and pc_inc pulse tally.
  always @(negedge clk) begin
    if (int'(pc_read) + int'(pc_readplusone) + int'(pc_inc) +
        int'(pc_write) + int'(pc_offset) > 1) overlap <= overlap + 1;
    if (pc_inc) inc_cnt <= inc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Advance until instr_valid; returns cycles taken (capped at 20).
  task automatic wait_valid(output int n);
    n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  int n;
  int inc0;

  initial begin
    reset = 1'b1; pc_rst = 1'b1; ack_en = 1'b1; instr_ready = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_target = 16'h0000; resume = 1'b0;
    tick(); tick();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_flags", {30'd0, halted, fault}, 32'd0);
    chk("rst_pc_din", {16'd0, pc_din}, 32'd0);

    // Test 1: zero-wait fetch of 12345678 from address 0.
    reset = 1'b0; pc_rst = 1'b0;
    tick();
    inc0 = inc_cnt;
    chk("t1_f0", {29'd0, mem_req, pc_read, pc_readplusone}, 32'b110);
    wait_valid(n);
    chk("t1_latency", n, 6);
    chk("t1_instr", instr, 32'h12345678);
    chk("t1_pc", {16'd0, pc_m}, 32'h0004);
    chk("t1_incs", inc_cnt - inc0, 2);

    // Test 2: absolute jump to 0100.
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("t2_accept", {31'd0, instr_valid}, 32'd0);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_target = 16'h0100;
    tick();
    cmd_valid = 1'b0;
    chk("t2_branch", {30'd0, pc_write, pc_offset}, 32'b10);
    chk("t2_pc_din", {16'd0, pc_din}, 32'h0100);
    tick();
    chk("t2_f0", {30'd0, pc_read, pc_write}, 32'b10);
    chk("t2_addr0", {16'd0, addr_m}, 32'h0100);
    tick();
    chk("t2_addr1", {15'd0, pc_readplusone, addr_m}, 32'h10101);
    wait_valid(n);
    chk("t2_instr", instr, 32'h40414243);
    chk("t2_pc", {16'd0, pc_m}, 32'h0104);

    // Test 3: relative branch by -8 from 0104.
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_target = 16'hFFF8;
    tick();
    cmd_valid = 1'b0;
    chk("t3_branch", {30'd0, pc_write, pc_offset}, 32'b01);
    tick();
    chk("t3_pc", {16'd0, pc_m}, 32'h00FC);
    wait_valid(n);
    chk("t3_instr", instr, 32'h3C3D3E3F);
    chk("t3_pc_after", {16'd0, pc_m}, 32'h0100);

    // Test 5: halt, then resume from current PC.
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_target = 16'h0000;
    tick();
    cmd_valid = 1'b0;
    chk("t5_halted", {30'd0, halted, mem_req}, 32'b10);
    tick(); tick();
    chk("t5_hold", {30'd0, halted, mem_req}, 32'b10);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("t5_resume", {15'd0, halted, pc_read, addr_m[14:0]}, {15'd0, 1'b0, 1'b1, 15'h0100});
    wait_valid(n);
    chk("t5_instr", instr, 32'h40414243);
    chk("t5_pc", {16'd0, pc_m}, 32'h0104);

    // Test 4: sequential fetch, ack withheld in F2 until timeout.
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b00;
    tick();
    cmd_valid = 1'b0;
    chk("t4_f0", {31'd0, pc_read}, 32'd1);
    tick();
    tick();
    chk("t4_inc0", {31'd0, pc_inc}, 32'd1);
    ack_en = 1'b0;
    tick();
    chk("t4_f2", {30'd0, pc_read, mem_req}, 32'b11);
    repeat (TO - 1) tick();
    chk("t4_no_fault_yet", {30'd0, fault, mem_req}, 32'b01);
    tick();
    chk("t4_fault", {30'd0, fault, mem_req}, 32'b10);
    chk("t4_strobes", {27'd0, pc_read, pc_readplusone, pc_inc, pc_write, pc_offset}, 32'd0);
    ack_en = 1'b1;
    tick(); tick();
    chk("t4_sticky", {31'd0, fault}, 32'd1);
    reset = 1'b1;
    tick();
    chk("t4_rst", {30'd0, fault, mem_req}, 32'd0);
    reset = 1'b0;
    tick();
    chk("t4_refetch", {30'd0, pc_read, mem_req}, 32'b11);

    // Test 6: reset during F3 with instr_ready high drops the partial word.
    instr_ready = 1'b1;
    tick(); tick(); tick(); tick();
    chk("t6_in_f3", {30'd0, pc_readplusone, mem_req}, 32'b11);
    reset = 1'b1;
    tick();
    chk("t6_instr", instr, 32'd0);
    chk("t6_valid", {31'd0, instr_valid}, 32'd0);
    reset = 1'b0;
    tick();
    wait_valid(n);
    chk("t6_latency", n, 6);
    chk("t6_instr_after", instr, 32'h48494A4B);
    chk("t6_pc", {16'd0, pc_m}, 32'h010C);

    chk("strobe_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
